sdram_burst_arbiter: RTL and testbench

Two-channel arbiter sharing the single SDRAM controller burst port (rd/wr_burst_req, len, addr, data, finish) between the SD-card BMP loader (channel 0) and the OV5640 frame writer/reader (channel 1). It replaces the mode-based static selection of burst signals with dynamic round-robin arbitration, so both requesters can use the SDRAM concurrently. It also handles zero-length requests locally and flags stalled bursts with a watchdog.

---
 rtl/sdram_burst_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_sdram_burst_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_burst_arbiter
// Shares the single SDRAM controller burst port between two requesters
// (channel 0: SD-card BMP loader, channel 1: OV5640 frame writer/reader)
// using round-robin arbitration. Within a channel, write beats read.
// Zero-length requests are answered locally with a finish pulse and are
// never forwarded. A watchdog raises a sticky flag on stalled bursts.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ch_en[1:0]            per-channel enable for new requests
//   cN_*_burst_req/len/addr, cN_wr_burst_data   requester side inputs
//   cN_wr_burst_data_req, cN_*_burst_finish, cN_rd_burst_data_valid
//                         handshakes routed to the granted channel
//   rd_burst_data_out     read data broadcast to both channels
//   rd/wr_burst_req/len/addr, wr_burst_data     master port to controller
//   wr_burst_data_req, *_burst_finish, rd_burst_data_valid, rd_burst_data
//                         controller handshake inputs
//   grant[1:0]            one-hot owner of the current burst
//   busy                  high in GRANT and BURST
//   timeout_err           sticky watchdog flag
// ---------------------------------------------------------------------------
module sdram_burst_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ch_en,
    input  logic        c0_rd_burst_req,
    input  logic        c0_wr_burst_req,
    input  logic [9:0]  c0_rd_burst_len,
    input  logic [9:0]  c0_wr_burst_len,
    input  logic [23:0] c0_rd_burst_addr,
    input  logic [23:0] c0_wr_burst_addr,
    input  logic [15:0] c0_wr_burst_data,
    output logic        c0_wr_burst_data_req,
    output logic        c0_wr_burst_finish,
    output logic        c0_rd_burst_finish,
    output logic        c0_rd_burst_data_valid,
    input  logic        c1_rd_burst_req,
    input  logic        c1_wr_burst_req,
    input  logic [9:0]  c1_rd_burst_len,
    input  logic [9:0]  c1_wr_burst_len,
    input  logic [23:0] c1_rd_burst_addr,
    input  logic [23:0] c1_wr_burst_addr,
    input  logic [15:0] c1_wr_burst_data,
    output logic        c1_wr_burst_data_req,
    output logic        c1_wr_burst_finish,
    output logic        c1_rd_burst_finish,
    output logic        c1_rd_burst_data_valid,
    output logic [15:0] rd_burst_data_out,
    output logic        rd_burst_req,
    output logic        wr_burst_req,
    output logic [9:0]  rd_burst_len,
    output logic [9:0]  wr_burst_len,
    output logic [23:0] rd_burst_addr,
    output logic [23:0] wr_burst_addr,
    output logic [15:0] wr_burst_data,
    input  logic        wr_burst_data_req,
    input  logic        wr_burst_finish,
    input  logic        rd_burst_finish,
    input  logic        rd_burst_data_valid,
    input  logic [15:0] rd_burst_data,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, BURST = 2'd2, DONE = 2'd3} state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [1:0]  r_grant;
    logic        r_sel;
    logic        r_is_wr;
    logic        r_zero;
    logic        r_local_finish;
    logic        r_last_served;
    logic [9:0]  r_len;
    logic [23:0] r_addr;
    logic        r_rd_req;
    logic        r_wr_req;
    logic [9:0]  r_rd_len;
    logic [9:0]  r_wr_len;
    logic [23:0] r_rd_addr;
    logic [23:0] r_wr_addr;
    logic [15:0] r_wd_cnt;
    logic        r_timeout_err;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_any;
    logic        w_pick;
    logic        w_pick_wr;
    logic [9:0]  w_pick_len;
    logic [23:0] w_pick_addr;
    logic        w_burst_done;
    logic [15:0] w_wd_next;

    // Channel selection: on a tie the channel that was not served last wins;
    // inside the winning channel a pending write beats a pending read.
    always_comb begin
        w_elig0 = ch_en[0] & (c0_rd_burst_req | c0_wr_burst_req);
        w_elig1 = ch_en[1] & (c1_rd_burst_req | c1_wr_burst_req);
        w_any   = w_elig0 | w_elig1;
        w_pick  = (w_elig0 && w_elig1) ? ~r_last_served : w_elig1;
        if (w_pick) begin
            w_pick_wr   = c1_wr_burst_req;
            w_pick_len  = c1_wr_burst_req ? c1_wr_burst_len  : c1_rd_burst_len;
            w_pick_addr = c1_wr_burst_req ? c1_wr_burst_addr : c1_rd_burst_addr;
        end else begin
            w_pick_wr   = c0_wr_burst_req;
            w_pick_len  = c0_wr_burst_req ? c0_wr_burst_len  : c0_rd_burst_len;
            w_pick_addr = c0_wr_burst_req ? c0_wr_burst_addr : c0_rd_burst_addr;
        end
        w_burst_done = (r_state == BURST) && (r_is_wr ? wr_burst_finish : rd_burst_finish);
        w_wd_next    = (r_wd_cnt == 16'hFFFF) ? r_wd_cnt : r_wd_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Zero-length grants skip BURST and spend their GRANT cycle emitting
    // the local finish pulse instead.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = GRANT;
            GRANT:   w_next_state = r_zero ? DONE : BURST;
            BURST:   if (w_burst_done) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake routing is purely combinational and only live during BURST,
    // so a stray finish outside a burst never reaches a requester.
    always_comb begin
        c0_wr_burst_data_req   = 1'b0;
        c1_wr_burst_data_req   = 1'b0;
        c0_wr_burst_finish     = 1'b0;
        c1_wr_burst_finish     = 1'b0;
        c0_rd_burst_finish     = 1'b0;
        c1_rd_burst_finish     = 1'b0;
        c0_rd_burst_data_valid = 1'b0;
        c1_rd_burst_data_valid = 1'b0;
        wr_burst_data          = 16'd0;
        busy                   = (r_state == GRANT) || (r_state == BURST);
        if (r_grant[0])      wr_burst_data = c0_wr_burst_data;
        else if (r_grant[1]) wr_burst_data = c1_wr_burst_data;
        if (r_state == BURST) begin
            if (r_is_wr) begin
                c0_wr_burst_data_req = r_grant[0] & wr_burst_data_req;
                c1_wr_burst_data_req = r_grant[1] & wr_burst_data_req;
                c0_wr_burst_finish   = r_grant[0] & wr_burst_finish;
                c1_wr_burst_finish   = r_grant[1] & wr_burst_finish;
            end else begin
                c0_rd_burst_data_valid = r_grant[0] & rd_burst_data_valid;
                c1_rd_burst_data_valid = r_grant[1] & rd_burst_data_valid;
                c0_rd_burst_finish     = r_grant[0] & rd_burst_finish;
                c1_rd_burst_finish     = r_grant[1] & rd_burst_finish;
            end
        end
        if (r_local_finish) begin
            if (r_is_wr) begin
                c0_wr_burst_finish = c0_wr_burst_finish | r_grant[0];
                c1_wr_burst_finish = c1_wr_burst_finish | r_grant[1];
            end else begin
                c0_rd_burst_finish = c0_rd_burst_finish | r_grant[0];
                c1_rd_burst_finish = c1_rd_burst_finish | r_grant[1];
            end
        end
    end

    // Datapath registers. Master len/addr of the idle direction keep their
    // last value; only the selected direction is reloaded in GRANT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant        <= 2'b00;
            r_sel          <= 1'b0;
            r_is_wr        <= 1'b0;
            r_zero         <= 1'b0;
            r_local_finish <= 1'b0;
            r_last_served  <= 1'b1;
            r_len          <= 10'd0;
            r_addr         <= 24'd0;
            r_rd_req       <= 1'b0;
            r_wr_req       <= 1'b0;
            r_rd_len       <= 10'd0;
            r_wr_len       <= 10'd0;
            r_rd_addr      <= 24'd0;
            r_wr_addr      <= 24'd0;
            r_wd_cnt       <= 16'd0;
            r_timeout_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel          <= w_pick;
                        r_grant        <= w_pick ? 2'b10 : 2'b01;
                        r_is_wr        <= w_pick_wr;
                        r_len          <= w_pick_len;
                        r_addr         <= w_pick_addr;
                        r_zero         <= (w_pick_len == 10'd0);
                        r_local_finish <= (w_pick_len == 10'd0);
                    end
                end
                GRANT: begin
                    r_local_finish <= 1'b0;
                    r_wd_cnt       <= 16'd0;
                    if (r_zero) begin
                        r_last_served <= r_sel;
                    end else if (r_is_wr) begin
                        r_wr_req  <= 1'b1;
                        r_wr_len  <= r_len;
                        r_wr_addr <= r_addr;
                    end else begin
                        r_rd_req  <= 1'b1;
                        r_rd_len  <= r_len;
                        r_rd_addr <= r_addr;
                    end
                end
                BURST: begin
                    // The watchdog only reports; the controller cannot be
                    // interrupted, so the burst keeps waiting for finish.
                    r_wd_cnt <= w_wd_next;
                    if (w_wd_next == TIMEOUT_CYCLES) r_timeout_err <= 1'b1;
                    if (w_burst_done) begin
                        r_wr_req      <= 1'b0;
                        r_rd_req      <= 1'b0;
                        r_last_served <= r_sel;
                    end
                end
                DONE: begin
                    r_grant <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign rd_burst_data_out = rd_burst_data;
    assign rd_burst_req      = r_rd_req;
    assign wr_burst_req      = r_wr_req;
    assign rd_burst_len      = r_rd_len;
    assign wr_burst_len      = r_wr_len;
    assign rd_burst_addr     = r_rd_addr;
    assign wr_burst_addr     = r_wr_addr;
    assign grant             = r_grant;
    assign timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_burst_arbiter
// Directed bench for sdram_burst_arbiter with a short watchdog limit (16).
// Each scenario task drives the requesters and a hand-played controller and
// compares the arbiter outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sdram_burst_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ch_en;
    logic        c0_rd_burst_req, c0_wr_burst_req;
    logic [9:0]  c0_rd_burst_len, c0_wr_burst_len;
    logic [23:0] c0_rd_burst_addr, c0_wr_burst_addr;
    logic [15:0] c0_wr_burst_data;
    logic        c0_wr_burst_data_req, c0_wr_burst_finish, c0_rd_burst_finish, c0_rd_burst_data_valid;
    logic        c1_rd_burst_req, c1_wr_burst_req;
    logic [9:0]  c1_rd_burst_len, c1_wr_burst_len;
    logic [23:0] c1_rd_burst_addr, c1_wr_burst_addr;
    logic [15:0] c1_wr_burst_data;
    logic        c1_wr_burst_data_req, c1_wr_burst_finish, c1_rd_burst_finish, c1_rd_burst_data_valid;
    logic [15:0] rd_burst_data_out;
    logic        rd_burst_req, wr_burst_req;
    logic [9:0]  rd_burst_len, wr_burst_len;
    logic [23:0] rd_burst_addr, wr_burst_addr;
    logic [15:0] wr_burst_data;
    logic        wr_burst_data_req, wr_burst_finish, rd_burst_finish, rd_burst_data_valid;
    logic [15:0] rd_burst_data;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout_err;

    int nCompared = 0;
    int nMismatched = 0;

    sdram_burst_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en),
        .c0_rd_burst_req(c0_rd_burst_req), .c0_wr_burst_req(c0_wr_burst_req),
        .c0_rd_burst_len(c0_rd_burst_len), .c0_wr_burst_len(c0_wr_burst_len),
        .c0_rd_burst_addr(c0_rd_burst_addr), .c0_wr_burst_addr(c0_wr_burst_addr),
        .c0_wr_burst_data(c0_wr_burst_data), .c0_wr_burst_data_req(c0_wr_burst_data_req),
        .c0_wr_burst_finish(c0_wr_burst_finish), .c0_rd_burst_finish(c0_rd_burst_finish),
        .c0_rd_burst_data_valid(c0_rd_burst_data_valid),
        .c1_rd_burst_req(c1_rd_burst_req), .c1_wr_burst_req(c1_wr_burst_req),
        .c1_rd_burst_len(c1_rd_burst_len), .c1_wr_burst_len(c1_wr_burst_len),
        .c1_rd_burst_addr(c1_rd_burst_addr), .c1_wr_burst_addr(c1_wr_burst_addr),
        .c1_wr_burst_data(c1_wr_burst_data), .c1_wr_burst_data_req(c1_wr_burst_data_req),
        .c1_wr_burst_finish(c1_wr_burst_finish), .c1_rd_burst_finish(c1_rd_burst_finish),
        .c1_rd_burst_data_valid(c1_rd_burst_data_valid),
        .rd_burst_data_out(rd_burst_data_out),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_finish(wr_burst_finish), .rd_burst_finish(rd_burst_finish),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ch_en = 2'b11;
        c0_rd_burst_req = 0; c0_wr_burst_req = 0; c1_rd_burst_req = 0; c1_wr_burst_req = 0;
        c0_rd_burst_len = 0; c0_wr_burst_len = 0; c1_rd_burst_len = 0; c1_wr_burst_len = 0;
        c0_rd_burst_addr = 0; c0_wr_burst_addr = 0; c1_rd_burst_addr = 0; c1_wr_burst_addr = 0;
        c0_wr_burst_data = 16'hC0C0; c1_wr_burst_data = 16'hC1C1;
        wr_burst_data_req = 0; wr_burst_finish = 0; rd_burst_finish = 0; rd_burst_data_valid = 0;
        rd_burst_data = 16'h0000;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearInputs();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One complete short burst starting with the arbiter in IDLE and the
    // request already present; the controller answers after one beat.
    task automatic serve(input logic [1:0] expGrant, input bit isWr, input logic [23:0] expAddr,
                         input logic [9:0] expLen, input bit dropReq);
        step();
        nCompared++; if (grant !== expGrant) begin nMismatched++; $display("[TB] FAIL serve_grant got=%b exp=%b", grant, expGrant); end
        nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL serve_busy_grant got=%b exp=1", busy); end
        nCompared++; if ((rd_burst_req | wr_burst_req) !== 1'b0) begin nMismatched++; $display("[TB] FAIL serve_req_early got=%b%b exp=00", rd_burst_req, wr_burst_req); end
        step();
        if (isWr) begin
            nCompared++; if ({rd_burst_req, wr_burst_req} !== 2'b01) begin nMismatched++; $display("[TB] FAIL serve_wr_req got=%b%b exp=01", rd_burst_req, wr_burst_req); end
            nCompared++; if (wr_burst_addr !== expAddr || wr_burst_len !== expLen) begin nMismatched++; $display("[TB] FAIL serve_wr_addr_len got=%h/%0d exp=%h/%0d", wr_burst_addr, wr_burst_len, expAddr, expLen); end
            wr_burst_data_req = 1'b1;
            #1;
            nCompared++; if ({c1_wr_burst_data_req, c0_wr_burst_data_req} !== expGrant) begin nMismatched++; $display("[TB] FAIL serve_data_req_route got=%b%b exp=%b", c1_wr_burst_data_req, c0_wr_burst_data_req, expGrant); end
            nCompared++; if (wr_burst_data !== (expGrant[1] ? 16'hC1C1 : 16'hC0C0)) begin nMismatched++; $display("[TB] FAIL serve_wr_data got=%h exp=%h", wr_burst_data, expGrant[1] ? 16'hC1C1 : 16'hC0C0); end
            wr_burst_data_req = 1'b0;
            wr_burst_finish = 1'b1;
            #1;
            nCompared++; if ({c1_wr_burst_finish, c0_wr_burst_finish} !== expGrant) begin nMismatched++; $display("[TB] FAIL serve_wr_finish_route got=%b%b exp=%b", c1_wr_burst_finish, c0_wr_burst_finish, expGrant); end
        end else begin
            nCompared++; if ({rd_burst_req, wr_burst_req} !== 2'b10) begin nMismatched++; $display("[TB] FAIL serve_rd_req got=%b%b exp=10", rd_burst_req, wr_burst_req); end
            nCompared++; if (rd_burst_addr !== expAddr || rd_burst_len !== expLen) begin nMismatched++; $display("[TB] FAIL serve_rd_addr_len got=%h/%0d exp=%h/%0d", rd_burst_addr, rd_burst_len, expAddr, expLen); end
            rd_burst_data_valid = 1'b1;
            rd_burst_data = 16'hBEEF;
            #1;
            nCompared++; if ({c1_rd_burst_data_valid, c0_rd_burst_data_valid} !== expGrant) begin nMismatched++; $display("[TB] FAIL serve_valid_route got=%b%b exp=%b", c1_rd_burst_data_valid, c0_rd_burst_data_valid, expGrant); end
            nCompared++; if (rd_burst_data_out !== 16'hBEEF) begin nMismatched++; $display("[TB] FAIL serve_rd_data got=%h exp=BEEF", rd_burst_data_out); end
            rd_burst_data_valid = 1'b0;
            rd_burst_finish = 1'b1;
            #1;
            nCompared++; if ({c1_rd_burst_finish, c0_rd_burst_finish} !== expGrant) begin nMismatched++; $display("[TB] FAIL serve_rd_finish_route got=%b%b exp=%b", c1_rd_burst_finish, c0_rd_burst_finish, expGrant); end
        end
        step();
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
        nCompared++; if ({rd_burst_req, wr_burst_req, busy} !== 3'b000) begin nMismatched++; $display("[TB] FAIL serve_done_state got=%b%b%b exp=000", rd_burst_req, wr_burst_req, busy); end
        nCompared++; if (grant !== expGrant) begin nMismatched++; $display("[TB] FAIL serve_done_grant got=%b exp=%b", grant, expGrant); end
        if (dropReq) begin
            if (isWr) begin if (expGrant[1]) c1_wr_burst_req = 0; else c0_wr_burst_req = 0; end
            else      begin if (expGrant[1]) c1_rd_burst_req = 0; else c0_rd_burst_req = 0; end
        end
        step();
        nCompared++; if (grant !== 2'b00) begin nMismatched++; $display("[TB] FAIL serve_idle_grant got=%b exp=00", grant); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        rd_burst_data = 16'h1234;
        #1;
        nCompared++; if ({grant, busy, rd_burst_req, wr_burst_req, timeout_err} !== 6'b0) begin nMismatched++; $display("[TB] FAIL reset_outputs got=%b exp=000000", {grant, busy, rd_burst_req, wr_burst_req, timeout_err}); end
        nCompared++; if (rd_burst_data_out !== 16'h1234) begin nMismatched++; $display("[TB] FAIL reset_rd_data_out got=%h exp=1234", rd_burst_data_out); end
        nCompared++; if ({wr_burst_len, rd_burst_len, wr_burst_addr, rd_burst_addr, wr_burst_data} !== 84'd0) begin nMismatched++; $display("[TB] FAIL reset_master_fields not all zero"); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        int cnt0 = 0;
        int cnt1 = 0;
        int fin0 = 0;
        doReset();
        c0_wr_burst_req = 1; c0_wr_burst_len = 10'd256; c0_wr_burst_addr = 24'h000100;
        step();
        nCompared++; if (grant !== 2'b01 || wr_burst_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL sw_grant got=%b/%b exp=01/0", grant, wr_burst_req); end
        step();
        nCompared++; if (wr_burst_req !== 1'b1 || wr_burst_len !== 10'd256 || wr_burst_addr !== 24'h000100) begin nMismatched++; $display("[TB] FAIL sw_master got=%b/%0d/%h exp=1/256/000100", wr_burst_req, wr_burst_len, wr_burst_addr); end
        for (int i = 0; i < 256; i++) begin
            wr_burst_data_req = 1'b1;
            #1;
            if (c0_wr_burst_data_req === 1'b1) cnt0++;
            if (c1_wr_burst_data_req === 1'b1) cnt1++;
            step();
        end
        wr_burst_data_req = 1'b0;
        nCompared++; if (cnt0 !== 256 || cnt1 !== 0) begin nMismatched++; $display("[TB] FAIL sw_data_req_count got=%0d/%0d exp=256/0", cnt0, cnt1); end
        wr_burst_finish = 1'b1;
        #1;
        if (c0_wr_burst_finish === 1'b1) fin0++;
        step();
        wr_burst_finish = 1'b0;
        c0_wr_burst_req = 1'b0;
        if (c0_wr_burst_finish === 1'b1) fin0++;
        nCompared++; if (wr_burst_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL sw_req_drop got=%b exp=0", wr_burst_req); end
        step();
        if (c0_wr_burst_finish === 1'b1) fin0++;
        nCompared++; if (fin0 !== 1) begin nMismatched++; $display("[TB] FAIL sw_finish_pulses got=%0d exp=1", fin0); end
        nCompared++; if (grant !== 2'b00 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL sw_idle got=%b/%b exp=00/0", grant, busy); end
    endtask

    task automatic test_round_robin();
        doReset();
        c0_rd_burst_req = 1; c0_rd_burst_len = 10'd4; c0_rd_burst_addr = 24'h000010;
        c1_rd_burst_req = 1; c1_rd_burst_len = 10'd8; c1_rd_burst_addr = 24'h000020;
        serve(2'b01, 1'b0, 24'h000010, 10'd4, 1'b0);
        serve(2'b10, 1'b0, 24'h000020, 10'd8, 1'b0);
        serve(2'b01, 1'b0, 24'h000010, 10'd4, 1'b0);
        serve(2'b10, 1'b0, 24'h000020, 10'd8, 1'b1);
        c0_rd_burst_req = 0;
    endtask

    task automatic test_write_priority();
        doReset();
        c0_rd_burst_req = 1; c0_rd_burst_len = 10'd3; c0_rd_burst_addr = 24'h000500;
        serve(2'b01, 1'b0, 24'h000500, 10'd3, 1'b1);
        c1_wr_burst_req = 1; c1_wr_burst_len = 10'd5; c1_wr_burst_addr = 24'h000300;
        c1_rd_burst_req = 1; c1_rd_burst_len = 10'd6; c1_rd_burst_addr = 24'h000400;
        c0_rd_burst_req = 1;
        serve(2'b10, 1'b1, 24'h000300, 10'd5, 1'b1);
        serve(2'b01, 1'b0, 24'h000500, 10'd3, 1'b1);
        serve(2'b10, 1'b0, 24'h000400, 10'd6, 1'b1);
        step();
        nCompared++; if (grant !== 2'b00) begin nMismatched++; $display("[TB] FAIL wp_all_served got=%b exp=00", grant); end
    endtask

    task automatic test_zero_len();
        doReset();
        c0_wr_burst_req = 1; c0_wr_burst_len = 10'd0; c0_wr_burst_addr = 24'h000055;
        step();
        nCompared++; if (grant !== 2'b01) begin nMismatched++; $display("[TB] FAIL zl_grant got=%b exp=01", grant); end
        nCompared++; if ({c1_wr_burst_finish, c0_wr_burst_finish, c0_rd_burst_finish} !== 3'b010) begin nMismatched++; $display("[TB] FAIL zl_finish_pulse got=%b exp=010", {c1_wr_burst_finish, c0_wr_burst_finish, c0_rd_burst_finish}); end
        nCompared++; if ({rd_burst_req, wr_burst_req} !== 2'b00) begin nMismatched++; $display("[TB] FAIL zl_no_master_req_k got=%b%b exp=00", rd_burst_req, wr_burst_req); end
        c0_wr_burst_req = 0;
        step();
        nCompared++; if ({c0_wr_burst_finish, wr_burst_req, busy} !== 3'b000) begin nMismatched++; $display("[TB] FAIL zl_done got=%b%b%b exp=000", c0_wr_burst_finish, wr_burst_req, busy); end
        step();
        nCompared++; if (grant !== 2'b00) begin nMismatched++; $display("[TB] FAIL zl_idle got=%b exp=00", grant); end
        // Channel 0 was served last, so channel 1 must take the next tie.
        c0_rd_burst_req = 1; c0_rd_burst_len = 10'd2; c0_rd_burst_addr = 24'h000A00;
        c1_rd_burst_req = 1; c1_rd_burst_len = 10'd2; c1_rd_burst_addr = 24'h000B00;
        serve(2'b10, 1'b0, 24'h000B00, 10'd2, 1'b1);
        c0_rd_burst_req = 0;
    endtask

    task automatic test_timeout();
        doReset();
        c1_wr_burst_req = 1; c1_wr_burst_len = 10'd8; c1_wr_burst_addr = 24'h002000;
        step();
        step();
        repeat (15) step();
        nCompared++; if (timeout_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_before_limit got=%b exp=0", timeout_err); end
        step();
        nCompared++; if (timeout_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL to_at_limit got=%b exp=1", timeout_err); end
        repeat (24) step();
        nCompared++; if (timeout_err !== 1'b1 || wr_burst_req !== 1'b1 || grant !== 2'b10) begin nMismatched++; $display("[TB] FAIL to_hold got=%b/%b/%b exp=1/1/10", timeout_err, wr_burst_req, grant); end
        wr_burst_finish = 1'b1;
        #1;
        nCompared++; if (c1_wr_burst_finish !== 1'b1) begin nMismatched++; $display("[TB] FAIL to_finish_route got=%b exp=1", c1_wr_burst_finish); end
        step();
        wr_burst_finish = 1'b0;
        c1_wr_burst_req = 1'b0;
        step();
        nCompared++; if (grant !== 2'b00 || wr_burst_req !== 1'b0 || timeout_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL to_complete got=%b/%b/%b exp=00/0/1", grant, wr_burst_req, timeout_err); end
    endtask

    task automatic test_mid_reset();
        doReset();
        c0_wr_burst_req = 1; c0_wr_burst_len = 10'd256; c0_wr_burst_addr = 24'h000100;
        step();
        step();
        wr_burst_data_req = 1'b1;
        repeat (100) step();
        wr_burst_finish = 1'b1;
        rst_n = 1'b0;
        #1;
        nCompared++; if ({grant, busy, rd_burst_req, wr_burst_req} !== 5'b0) begin nMismatched++; $display("[TB] FAIL mr_state got=%b exp=00000", {grant, busy, rd_burst_req, wr_burst_req}); end
        nCompared++; if ({c0_wr_burst_data_req, c0_wr_burst_finish, c1_wr_burst_finish, c0_rd_burst_finish} !== 4'b0) begin nMismatched++; $display("[TB] FAIL mr_routed got=%b exp=0000", {c0_wr_burst_data_req, c0_wr_burst_finish, c1_wr_burst_finish, c0_rd_burst_finish}); end
        clearInputs();
        step();
        rst_n = 1'b1;
        c0_rd_burst_req = 1; c0_rd_burst_len = 10'd7; c0_rd_burst_addr = 24'h000700;
        c1_rd_burst_req = 1; c1_rd_burst_len = 10'd9; c1_rd_burst_addr = 24'h000900;
        serve(2'b01, 1'b0, 24'h000700, 10'd7, 1'b1);
        c1_rd_burst_req = 0;
    endtask

    task automatic test_enable_and_stray();
        doReset();
        ch_en = 2'b10;
        c0_rd_burst_req = 1; c0_rd_burst_len = 10'd4; c0_rd_burst_addr = 24'h000123;
        repeat (3) step();
        nCompared++; if (grant !== 2'b00 || rd_burst_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL en_disabled got=%b/%b exp=00/0", grant, rd_burst_req); end
        wr_burst_finish = 1; rd_burst_finish = 1; wr_burst_data_req = 1; rd_burst_data_valid = 1;
        #1;
        nCompared++; if ({c0_wr_burst_finish, c0_rd_burst_finish, c0_wr_burst_data_req, c0_rd_burst_data_valid} !== 4'b0) begin nMismatched++; $display("[TB] FAIL stray_routing got=%b exp=0000", {c0_wr_burst_finish, c0_rd_burst_finish, c0_wr_burst_data_req, c0_rd_burst_data_valid}); end
        wr_burst_finish = 0; rd_burst_finish = 0; wr_burst_data_req = 0; rd_burst_data_valid = 0;
        ch_en = 2'b01;
        serve(2'b01, 1'b0, 24'h000123, 10'd4, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_write_priority();
        test_zero_len();
        test_timeout();
        test_mid_reset();
        test_enable_and_stray();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
